uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Receive-side counterpart of the UART transmitter.
- Deserialises an asynchronous 8N1-style serial line (one start bit, WORD_SIZE data bits, MSB first, one stop bit) into parallel words.
- Flags each good word with a one-cycle valid pulse and each bad stop bit with a one-cycle framing-error pulse.
- Sits between the external rx pin and the consumer logic (FIFO or controller).

Parameters:
- WORD_SIZE, 8: data bits per frame.
- CLOCK_FREQ, 50000000: clk frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s. BIT_TICKS = CLOCK_FREQ/BAUD_RATE (integer divide) and HALF = BIT_TICKS/2. BIT_TICKS >= 4 is required.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idle high.
- data_recv  output  WORD_SIZE  last correctly framed word; held until the next good frame.
- rx_valid_o  output  1  one-cycle pulse when data_recv has just been updated.
- rx_frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - data_recv = 0; rx_valid_o = 0; rx_frame_err_o = 0; rx_busy_o = 0.
  - state = IDLE; sync1 = sync2 = 0; armed = 0; counters = 0; shift register = 0.
- Synchroniser:
  - sync1 <= rx; sync2 <= sync1. All decisions use sync2 only.
- IDLE:
  - Every entry into IDLE, including reset, clears armed.
  - Each cycle with sync2 = 1 sets armed.
  - When armed = 1 and sync2 = 0: go to START, tick counter = 0.
  - A line held low through or after reset, or after a framing error, never starts a frame until it has been seen high.
- START:
  - Tick counter increments each cycle.
  - At the cycle where the counter equals HALF-1, sample sync2.
  - Sample 0: go to DATA, counter = 0, bit counter = 0.
  - Sample 1 (glitch): go to IDLE, with no pulse on either output.
- DATA:
  - Counter runs 0..BIT_TICKS-1. At BIT_TICKS-1, sample sync2 into the shift register: shift left, new bit into the LSB, so the first received bit ends up as the MSB. Then reset the counter.
  - After the WORD_SIZE-th sample: go to STOP.
- STOP:
  - At counter BIT_TICKS-1, sample sync2.
  - Sample 1: data_recv <= shift register, rx_valid_o = 1 for exactly one cycle.
  - Sample 0: rx_frame_err_o = 1 for one cycle; data_recv unchanged.
  - Either way, go to IDLE.
- Timing:
  - Let E0 be the clock edge at which sync1 first captures rx low, with armed already set.
  - The start decision is made at E2.
  - Start sample at E(HALF+2).
  - Data bit i (0 = first) sampled at E(HALF+2+(i+1)*BIT_TICKS).
  - Stop sample, and the rx_valid_o / rx_frame_err_o register update, at E(HALF+2+(WORD_SIZE+1)*BIT_TICKS).
  - Pulses are visible for the following cycle.
- Back-to-back frames:
  - A start edge arriving any time after the stop-bit sample is accepted. The remaining half stop bit re-arms the block.
  - No gap beyond one stop bit is required.
- rx_valid_o and rx_frame_err_o are never high in the same cycle.
- Reset mid-frame: abort immediately to IDLE, unarmed. Outputs return to reset values, including data_recv = 0. No pulse is emitted.
- No bit-level oversampling or majority vote; a single sample per bit at its centre.

Test Plan:
All scenarios use CLOCK_FREQ=16, BAUD_RATE=1 (BIT_TICKS=16, HALF=8), with 16 clk cycles per line bit.

- Idle line, then frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> rx_valid_o high for exactly one cycle after edge E154; data_recv = 0xA5; rx_frame_err_o stays 0; rx_busy_o high from E2 through E154.
- Low glitch of 3 cycles on the idle line -> rx_busy_o high for ~9 cycles, then 0; no valid or error pulse; data_recv unchanged.
- Frame 0x3C with stop bit 0, then line held low for 100 cycles -> one rx_frame_err_o pulse; data_recv keeps the previous 0xA5; no new start while low. Line high, then frame 0x81 -> data_recv = 0x81.
- Back-to-back frames 0x00 then 0xFF, each with exactly one stop bit -> two valid pulses 160 cycles apart; data 0x00 then 0xFF.
- rst asserted for 1 cycle during data bit 4 of a frame -> all outputs 0 the next cycle. The remainder of the frame produces no pulse. The next full frame 0x5A is received correctly.
- Line held low across reset release -> no frame starts until the line goes high. After that, frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// Serial-to-parallel receiver: one start bit, WORD_SIZE data bits MSB first, one stop bit.
// A single centre-of-bit sample per bit, taken from a two-flop synchronised copy of rx.
//
// state | meaning
// IDLE  | waiting for a falling edge on a line that has been seen high (armed)
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling WORD_SIZE data bits, one per BIT_TICKS
// STOP  | sampling the stop bit; emits valid or framing-error pulse
module uart_receiver #(
   parameter int WORD_SIZE  = 8,
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 9600
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [WORD_SIZE-1:0] data_recv,
   output logic                 rx_valid_o,
   output logic                 rx_frame_err_o,
   output logic                 rx_busy_o
);

   localparam int BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF      = BIT_TICKS / 2;
   localparam int CNT_W     = $clog2(BIT_TICKS + 1);
   localparam int BIT_W     = $clog2(WORD_SIZE + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state;
   logic                 sync1;
   logic                 sync2;
   logic                 armed;
   logic [CNT_W-1:0]     tick;
   logic [BIT_W-1:0]     bit_cnt;
   logic [WORD_SIZE-1:0] shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         sync1          <= 1'b0;
         sync2          <= 1'b0;
         armed          <= 1'b0;
         tick           <= '0;
         bit_cnt        <= '0;
         shift          <= '0;
         data_recv      <= '0;
         rx_valid_o     <= 1'b0;
         rx_frame_err_o <= 1'b0;
         rx_busy_o      <= 1'b0;
      end else begin
         sync1          <= rx;
         sync2          <= sync1;
         rx_valid_o     <= 1'b0;
         rx_frame_err_o <= 1'b0;
         case (state)
            IDLE: begin
               // armed guards against a line that was low at reset or after a framing error
               if (armed && !sync2) begin
                  state     <= START;
                  tick      <= '0;
                  rx_busy_o <= 1'b1;
               end else if (sync2) begin
                  armed <= 1'b1;
               end
            end
            START: begin
               if (tick == CNT_W'(HALF - 1)) begin
                  tick <= '0;
                  if (!sync2) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     state     <= IDLE;
                     armed     <= 1'b0;
                     rx_busy_o <= 1'b0;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            DATA: begin
               if (tick == CNT_W'(BIT_TICKS - 1)) begin
                  tick  <= '0;
                  shift <= {shift[WORD_SIZE-2:0], sync2};
                  if (bit_cnt == BIT_W'(WORD_SIZE - 1)) begin
                     state <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            STOP: begin
               if (tick == CNT_W'(BIT_TICKS - 1)) begin
                  tick      <= '0;
                  state     <= IDLE;
                  armed     <= 1'b0;
                  rx_busy_o <= 1'b0;
                  if (sync2) begin
                     data_recv  <= shift;
                     rx_valid_o <= 1'b1;
                  end else begin
                     rx_frame_err_o <= 1'b1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               armed     <= 1'b0;
               rx_busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit (BIT_TICKS=16, HALF=8).
// Frame helpers drive the line; a negedge monitor records pulses and busy edges.
module tb_uart_receiver;

   localparam int BT = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data_recv;
   logic       rx_valid_o;
   logic       rx_frame_err_o;
   logic       rx_busy_o;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int last_valid_cyc = 0;
   int busy_rise_cnt = 0;
   int busy_rise_cyc = 0;
   int busy_fall_cyc = 0;
   logic busy_prev = 1'b0;
   int frame_start_cyc = 0;

   always #5 clk = ~clk;

   uart_receiver #(.WORD_SIZE(8), .CLOCK_FREQ(16), .BAUD_RATE(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx             (rx),
      .data_recv      (data_recv),
      .rx_valid_o     (rx_valid_o),
      .rx_frame_err_o (rx_frame_err_o),
      .rx_busy_o      (rx_busy_o)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid_o === 1'b1) begin
         valid_cnt      = valid_cnt + 1;
         last_valid_cyc = cyc;
      end
      if (rx_frame_err_o === 1'b1) err_cnt = err_cnt + 1;
      if (rx_valid_o === 1'b1 && rx_frame_err_o === 1'b1) both_cnt = both_cnt + 1;
      if (rx_busy_o === 1'b1 && !busy_prev) begin
         busy_rise_cnt = busy_rise_cnt + 1;
         busy_rise_cyc = cyc;
      end
      if (rx_busy_o !== 1'b1 && busy_prev) busy_fall_cyc = cyc;
      busy_prev = (rx_busy_o === 1'b1);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      frame_start_cyc = cyc;
      rx = 1'b0;
      tick(BT);
      for (int i = 7; i >= 0; i--) begin
         rx = d[i];
         tick(BT);
      end
      rx = stop;
      tick(BT);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         low_after;
      int         gap;
      int         exp_valid;
      int         exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[4];
   int   vcyc[4];
   int   v0, e0, r0;

   initial begin
      vecs[0] = '{d: 8'h3C, stop: 1'b0, low_after: 100, gap: 20, exp_valid: 0, exp_err: 1, exp_data: 8'hA5};
      vecs[1] = '{d: 8'h81, stop: 1'b1, low_after: 0,   gap: 20, exp_valid: 1, exp_err: 0, exp_data: 8'h81};
      vecs[2] = '{d: 8'h00, stop: 1'b1, low_after: 0,   gap: 0,  exp_valid: 1, exp_err: 0, exp_data: 8'h00};
      vecs[3] = '{d: 8'hFF, stop: 1'b1, low_after: 0,   gap: 20, exp_valid: 1, exp_err: 0, exp_data: 8'hFF};

      rx  = 1'b1;
      rst = 1'b1;
      tick(3);
      check("reset data_recv", 32'(data_recv), 32'h0);
      check("reset valid", 32'(rx_valid_o), 32'h0);
      check("reset frame_err", 32'(rx_frame_err_o), 32'h0);
      check("reset busy", 32'(rx_busy_o), 32'h0);
      rst = 1'b0;
      tick(20);

      // Frame 0xA5 with cycle-exact timing: busy rises at E2, valid and busy fall at E154
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'hA5, 1'b1);
      tick(20);
      check("a5 valid count", 32'(valid_cnt - v0), 32'd1);
      check("a5 err count", 32'(err_cnt - e0), 32'd0);
      check("a5 data", 32'(data_recv), 32'hA5);
      check("a5 valid cycle", 32'(last_valid_cyc - frame_start_cyc), 32'd155);
      check("a5 busy rise", 32'(busy_rise_cyc - frame_start_cyc), 32'd3);
      check("a5 busy fall", 32'(busy_fall_cyc - frame_start_cyc), 32'd155);

      // 3-cycle low glitch: rejected at the start-bit centre
      v0 = valid_cnt; e0 = err_cnt; r0 = busy_rise_cnt;
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(30);
      check("glitch busy rises", 32'(busy_rise_cnt - r0), 32'd1);
      check("glitch busy width", 32'(busy_fall_cyc - busy_rise_cyc), 32'd8);
      check("glitch valid count", 32'(valid_cnt - v0), 32'd0);
      check("glitch err count", 32'(err_cnt - e0), 32'd0);
      check("glitch data", 32'(data_recv), 32'hA5);
      check("glitch busy idle", 32'(rx_busy_o), 32'h0);

      for (int i = 0; i < 4; i++) begin
         v0 = valid_cnt; e0 = err_cnt;
         send_frame(vecs[i].d, vecs[i].stop);
         if (vecs[i].low_after > 0) begin
            r0 = busy_rise_cnt;
            rx = 1'b0;
            tick(vecs[i].low_after);
            check("held low no start", 32'(busy_rise_cnt - r0), 32'd0);
            check("held low busy", 32'(rx_busy_o), 32'h0);
         end
         rx = 1'b1;
         tick(vecs[i].gap);
         check("vec valid count", 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
         check("vec err count", 32'(err_cnt - e0), 32'(vecs[i].exp_err));
         check("vec data", 32'(data_recv), 32'(vecs[i].exp_data));
         if (vecs[i].exp_valid == 1)
            check("vec valid cycle", 32'(last_valid_cyc - frame_start_cyc), 32'd155);
         vcyc[i] = last_valid_cyc;
      end
      check("back-to-back spacing", 32'(vcyc[3] - vcyc[2]), 32'd160);

      // Reset during data bit 4 of frame 0x0F; remaining bits are high so nothing restarts
      tick(10);
      v0 = valid_cnt; e0 = err_cnt;
      rx = 1'b0;
      tick(BT);
      for (int i = 7; i >= 4; i--) begin
         rx = 1'(8'h0F >> i);
         tick(BT);
      end
      rx = 1'b1;
      tick(8);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midreset data", 32'(data_recv), 32'h0);
      check("midreset valid", 32'(rx_valid_o), 32'h0);
      check("midreset err", 32'(rx_frame_err_o), 32'h0);
      check("midreset busy", 32'(rx_busy_o), 32'h0);
      tick(7 + 3 * BT + BT + 32);
      check("midreset no valid", 32'(valid_cnt - v0), 32'd0);
      check("midreset no err", 32'(err_cnt - e0), 32'd0);
      check("midreset data held", 32'(data_recv), 32'h0);

      v0 = valid_cnt;
      send_frame(8'h5A, 1'b1);
      tick(20);
      check("5a valid count", 32'(valid_cnt - v0), 32'd1);
      check("5a data", 32'(data_recv), 32'h5A);

      // Line low across reset release must not start a frame
      rx  = 1'b0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      r0 = busy_rise_cnt; v0 = valid_cnt; e0 = err_cnt;
      tick(60);
      check("low reset no start", 32'(busy_rise_cnt - r0), 32'd0);
      check("low reset busy", 32'(rx_busy_o), 32'h0);
      rx = 1'b1;
      tick(20);
      send_frame(8'h12, 1'b1);
      tick(20);
      check("12 valid count", 32'(valid_cnt - v0), 32'd1);
      check("12 err count", 32'(err_cnt - e0), 32'd0);
      check("12 data", 32'(data_recv), 32'h12);

      check("valid and err never together", 32'(both_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
